// File: rtl/twdl_stage_seq.sv
// Sequencer for the mixed-radix (2/3/4/5) twiddle-multiply stage: latches a per-stage
// config, steps twiddle numerators with each accepted butterfly and tracks the multiplier drain.
module twdl_stage_seq #(
  parameter int wCnt  = 12,
  parameter int TMO   = 64,
  parameter int wPend = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      cfg_factor,
  input  logic [wCnt-1:0] cfg_demontr,
  input  logic [wCnt-1:0] cfg_span,
  input  logic [wCnt-1:0] cfg_nbfly,
  input  logic            bfly_val,
  input  logic            tw_out_val,
  output logic            tw_in_val,
  output logic [2:0]      factor,
  output logic [wCnt-1:0] twdl_numrtr [0:4],
  output logic [wCnt-1:0] twdl_demontr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int wTmo = $clog2(TMO + 1);

  logic [1:0]      r_state;
  logic [2:0]      r_factor;
  logic [wCnt-1:0] r_demontr;
  logic [wCnt-1:0] r_span;
  logic [wCnt-1:0] r_nbfly;
  logic [wCnt-1:0] r_k;
  logic [wCnt-1:0] r_bcnt;
  logic [wCnt-1:0] r_acc [1:4];
  logic [wPend-1:0] r_pend;
  logic [wTmo-1:0] r_tmo;
  logic            r_err;

  logic w_cfg_ok;
  logic w_launch;
  logic w_accept;
  logic w_kwrap;
  logic w_last;
  logic w_timeout;
  logic w_pend_ovf;
  logic w_pend_unf;

  function automatic logic cfg_legal(input logic [2:0] f, input logic [wCnt-1:0] span,
                                     input logic [wCnt-1:0] nbfly);
    return (f >= 3'd2) && (f <= 3'd5) && (span != '0) && (nbfly != '0);
  endfunction

  assign w_cfg_ok   = cfg_legal(cfg_factor, cfg_span, cfg_nbfly);
  assign w_launch   = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_accept   = bfly_val && (r_state == S_RUN);
  assign w_kwrap    = (r_k == r_span - 1'b1);
  assign w_last     = (r_bcnt == r_nbfly - 1'b1);
  assign w_timeout  = (r_state == S_DRAIN) && (r_pend != '0) && !tw_out_val &&
                      (r_tmo == wTmo'(TMO - 1));
  assign w_pend_ovf = w_accept && !tw_out_val && (r_pend == '1);
  assign w_pend_unf = tw_out_val && !w_accept && (r_pend == '0);

  // Control FSM and latched stage configuration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_factor  <= '0;
      r_demontr <= '0;
      r_span    <= '0;
      r_nbfly   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state   <= S_RUN;
            r_factor  <= cfg_factor;
            r_demontr <= cfg_demontr;
            r_span    <= cfg_span;
            r_nbfly   <= cfg_nbfly;
          end
        end
        S_RUN: begin
          if (w_accept && w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_pend == '0 || w_timeout) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Twiddle index k and per-leg accumulators acc[p] = k*p, stepped without multipliers
  always_ff @(posedge clk) begin
    if (!rst_n || w_launch) begin
      r_k    <= '0;
      r_bcnt <= '0;
      for (int p = 1; p <= 4; p++) r_acc[p] <= '0;
    end else if (w_accept) begin
      r_bcnt <= r_bcnt + 1'b1;
      if (w_kwrap) begin
        r_k <= '0;
        for (int p = 1; p <= 4; p++) r_acc[p] <= '0;
      end else begin
        r_k <= r_k + 1'b1;
        for (int p = 1; p <= 4; p++) r_acc[p] <= r_acc[p] + wCnt'(p);
      end
    end
  end

  // Outstanding multiplier outputs; saturates at both ends
  always_ff @(posedge clk) begin
    if (!rst_n || w_timeout) begin
      r_pend <= '0;
    end else if (w_accept && !tw_out_val && !w_pend_ovf) begin
      r_pend <= r_pend + 1'b1;
    end else if (tw_out_val && !w_accept && !w_pend_unf) begin
      r_pend <= r_pend - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != S_DRAIN || tw_out_val) r_tmo <= '0;
    else r_tmo <= r_tmo + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= 1'b0;
    else r_err <= (start && r_state == S_IDLE && !w_cfg_ok) ||
                  (start && r_state != S_IDLE) ||
                  w_pend_ovf || w_pend_unf || w_timeout;
  end

  always_comb begin
    twdl_numrtr[0] = '0;
    for (int p = 1; p <= 4; p++)
      twdl_numrtr[p] = (3'(p) < r_factor) ? r_acc[p] : '0;
  end

  assign tw_in_val    = w_accept;
  assign factor       = r_factor;
  assign twdl_demontr = r_demontr;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;

endmodule

// File: tb/tb_twdl_stage_seq.sv
// Bench for twdl_stage_seq: scoreboard of expected numerators per accepted butterfly,
// fixed-delay multiplier model, and directed frame / error / timeout / reset scenarios.
module tb_twdl_stage_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  cfg_factor;
  logic [11:0] cfg_demontr, cfg_span, cfg_nbfly;
  logic        bfly_val;
  logic        tw_out_val;
  logic        tw_in_val;
  logic [2:0]  factor;
  logic [11:0] twdl_numrtr [0:4];
  logic [11:0] twdl_demontr;
  logic        busy, done, err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [63:0] sb_q [$];
  int m_factor, m_span, m_k, m_left;

  logic [3:0] pipe;
  logic       mul_en;
  logic       force_out;

  twdl_stage_seq #(.wCnt(12), .TMO(64), .wPend(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_factor(cfg_factor),
    .cfg_demontr(cfg_demontr), .cfg_span(cfg_span), .cfg_nbfly(cfg_nbfly),
    .bfly_val(bfly_val), .tw_out_val(tw_out_val), .tw_in_val(tw_in_val),
    .factor(factor), .twdl_numrtr(twdl_numrtr), .twdl_demontr(twdl_demontr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign tw_out_val = pipe[3] | force_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int f, input int k);
    logic [63:0] w;
    w = '0;
    w[62:60] = 3'(f);
    for (int p = 1; p <= 4; p++)
      if (p < f) w[p*12 +: 12] = 12'(k * p);
    return w;
  endfunction

  function automatic logic [63:0] dut_word();
    return {1'b0, factor, twdl_numrtr[4], twdl_numrtr[3], twdl_numrtr[2],
            twdl_numrtr[1], twdl_numrtr[0]};
  endfunction

  // Fixed 4-cycle multiplier latency model
  always @(negedge clk) begin
    if (!rst_n) pipe <= '0;
    else pipe <= {pipe[2:0], tw_in_val & mul_en};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (tw_in_val) begin
        if (sb_q.size() == 0) chk("unexpected_accept", 64'd1, 64'd0);
        else chk("numrtr", dut_word(), sb_q.pop_front());
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_tw_in_val"}, tw_in_val, 0);
    chk({tag, "_outs"}, {dut_word(), twdl_demontr}, 0);
  endtask

  task automatic do_start(input int f, input int d, input int s, input int n);
    cfg_factor = 3'(f); cfg_demontr = 12'(d); cfg_span = 12'(s); cfg_nbfly = 12'(n);
    start = 1'b1;
    if (f >= 2 && f <= 5 && s != 0 && n != 0) begin
      m_factor = f; m_span = s; m_k = 0; m_left = n;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] pat, input int len, input int glitch);
    for (int i = 0; i < len; i++) begin
      bfly_val = pat[i];
      if (i == glitch) begin
        start = 1'b1; cfg_factor = 3'd5; cfg_demontr = 12'd40;
        cfg_span = 12'd2; cfg_nbfly = 12'd2;
      end else begin
        start = 1'b0;
      end
      if (pat[i] && m_left > 0) begin
        sb_q.push_back(exp_word(m_factor, m_k));
        m_k = (m_k == m_span - 1) ? 0 : m_k + 1;
        m_left--;
      end
      @(posedge clk); #1;
    end
    bfly_val = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc, output int ncyc);
    int n;
    n = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk({tag, "_done_seen"}, done, 1);
    ncyc = n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, nc;
    rst_n = 1'b0; start = 1'b0; bfly_val = 1'b0; mul_en = 1'b1; force_out = 1'b0;
    cfg_factor = '0; cfg_demontr = '0; cfg_span = '0; cfg_nbfly = '0;
    m_factor = 0; m_span = 1; m_k = 0; m_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: radix-3 frame, continuous valid
    d0 = done_cnt; e0 = err_cnt;
    do_start(3, 12, 4, 8);
    chk("t1_busy", busy, 1);
    chk("t1_demontr", twdl_demontr, 12);
    feed(16'h00FF, 8, -1);
    wait_done("t1", 100, nc);
    chk("t1_busy_in_done", busy, 1);
    @(negedge clk);
    chk("t1_busy_fall", busy, 0);
    repeat (3) @(posedge clk); #1;
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_no_err", err_cnt - e0, 0);
    chk("t1_sb_empty", sb_q.size(), 0);

    // 2: radix-5 with gaps in bfly_val
    d0 = done_cnt;
    do_start(5, 20, 4, 4);
    feed(16'b101101, 6, -1);
    wait_done("t2", 100, nc);
    repeat (2) @(posedge clk); #1;
    chk("t2_done_once", done_cnt - d0, 1);
    chk("t2_sb_empty", sb_q.size(), 0);

    // 3: illegal configurations
    d0 = done_cnt; e0 = err_cnt;
    do_start(6, 12, 4, 8);
    repeat (2) @(posedge clk); #1;
    chk("t3_f6_err", err_cnt - e0, 1);
    chk("t3_f6_busy", busy, 0);
    do_start(3, 12, 4, 0);
    repeat (2) @(posedge clk); #1;
    chk("t3_nb0_err", err_cnt - e0, 2);
    chk("t3_nb0_busy", busy, 0);
    do_start(4, 12, 0, 4);
    repeat (2) @(posedge clk); #1;
    chk("t3_sp0_err", err_cnt - e0, 3);
    chk("t3_no_done", done_cnt - d0, 0);

    // 4: start pulsed while running
    d0 = done_cnt; e0 = err_cnt;
    do_start(3, 12, 4, 8);
    feed(16'h00FF, 8, 3);
    chk("t4_factor_held", factor, 3);
    chk("t4_demontr_held", twdl_demontr, 12);
    wait_done("t4", 100, nc);
    repeat (2) @(posedge clk); #1;
    chk("t4_err_once", err_cnt - e0, 1);
    chk("t4_done_once", done_cnt - d0, 1);
    chk("t4_sb_empty", sb_q.size(), 0);

    // 5: drain timeout with multiplier outputs withheld
    mul_en = 1'b0;
    do_start(2, 2, 1, 3);
    feed(16'h0007, 3, -1);
    wait_done("t5", 200, nc);
    chk("t5_tmo_cycles", nc, 65);
    chk("t5_err_with_done", err, 1);
    @(negedge clk);
    chk("t5_idle", busy, 0);
    mul_en = 1'b1;
    repeat (6) @(posedge clk); #1;

    // 6: reset in the middle of a frame, then restart
    do_start(3, 12, 4, 8);
    feed(16'h0003, 2, -1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    bfly_val = 1'b1;
    @(negedge clk);
    check_zero("t6_rst");
    @(posedge clk); #1;
    rst_n = 1'b1; bfly_val = 1'b0;
    sb_q.delete(); m_left = 0;
    d0 = done_cnt;
    do_start(3, 12, 4, 4);
    feed(16'h000F, 4, -1);
    wait_done("t6", 100, nc);
    repeat (2) @(posedge clk); #1;
    chk("t6_done_once", done_cnt - d0, 1);

    // tw_out_val with nothing outstanding
    e0 = err_cnt;
    force_out = 1'b1;
    @(posedge clk); #1;
    force_out = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("unf_err", err_cnt - e0, 1);
    chk("unf_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
